// File: rtl/spectrum_draw_ctrl_pkg.sv
// Shared types, default geometry and colour constants for the spectrum bar renderer.
package spectrum_pkg;

  // Default drawing geometry: 16 bars of 20 columns on a 240-row screen.
  localparam int DEF_NUM_BINS = 16;
  localparam int DEF_BAR_W    = 20;
  localparam int DEF_GAP_W    = 2;
  localparam int DEF_SCREEN_H = 240;

  // Fixed bus widths of the magnitude memory and pixel sink.
  localparam int ADDR_W = 4;
  localparam int MAG_W  = 9;
  localparam int X_W    = 9;
  localparam int Y_W    = 8;
  localparam int RGB_W  = 24;

  // RGB888 colours.
  localparam logic [RGB_W-1:0] DEF_BAR_COLOR = 24'h00FF40;
  localparam logic [RGB_W-1:0] DEF_BG_COLOR  = 24'h000000;

  // Drawing sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_WAIT = 3'd2,
    DRAW    = 3'd3,
    FIN     = 3'd4
  } draw_state_e;

  // Limits a raw magnitude to the screen height so oversized bins draw a full bar.
  function automatic logic [MAG_W-1:0] clampHeight(input logic [MAG_W-1:0] mag,
                                                   input int limit);
    if (int'(mag) >= limit) begin
      return MAG_W'(limit);
    end
    return mag;
  endfunction

endpackage

// File: rtl/spectrum_draw_ctrl_if.sv
// Bundle of frame control, magnitude-memory read port and pixel-write handshake.
interface spectrum_draw_ctrl_if;
  import spectrum_pkg::*;

  // Frame control
  logic              frame_start;
  logic              busy;
  logic              done;
  logic              overrun;

  // Magnitude memory read port (data returns one cycle after the address)
  logic [ADDR_W-1:0] bin_addr;
  logic [MAG_W-1:0]  bin_data;

  // Pixel write stream
  logic              pix_valid;
  logic              pix_ready;
  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;
  logic [RGB_W-1:0]  pix_color;

  // The draw controller side
  modport master (
    input  frame_start, bin_data, pix_ready,
    output busy, done, overrun, bin_addr, pix_valid, pix_x, pix_y, pix_color
  );

  // The surrounding system: frame requester, magnitude memory and pixel sink
  modport slave (
    output frame_start, bin_data, pix_ready,
    input  busy, done, overrun, bin_addr, pix_valid, pix_x, pix_y, pix_color
  );

endinterface

// File: rtl/spectrum_draw_ctrl_pixel_scan_counter.sv
// Column/row scan counter for one bar: rows are the inner loop, columns the outer.
module pixel_scan_counter #(
  parameter int BAR_W    = 20,
  parameter int SCREEN_H = 240,
  parameter int OFF_W    = 5,
  parameter int Y_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_advance,
  output logic [OFF_W-1:0] o_offset,
  output logic [Y_W-1:0]   o_y,
  output logic             o_last
);

  logic [OFF_W-1:0] r_offset;
  logic [Y_W-1:0]   r_y;
  logic             w_y_wrap;
  logic             w_off_wrap;

  assign w_y_wrap   = (r_y == Y_W'(SCREEN_H - 1));
  assign w_off_wrap = (r_offset == OFF_W'(BAR_W - 1));

  // Step y on every accepted pixel; when y wraps, move to the next column.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_offset <= '0;
      r_y      <= '0;
    end else if (i_advance) begin
      if (w_y_wrap) begin
        r_y      <= '0;
        r_offset <= w_off_wrap ? '0 : r_offset + 1'b1;
      end else begin
        r_y <= r_y + 1'b1;
      end
    end
  end

  assign o_offset = r_offset;
  assign o_y      = r_y;
  assign o_last   = w_y_wrap && w_off_wrap;

endmodule

// File: rtl/spectrum_draw_ctrl.sv
// Spectrum bar renderer: reads one magnitude per bar and streams every pixel of
// the bar (bar colour or background) to a valid/ready pixel sink.
module spectrum_draw_ctrl
  import spectrum_pkg::*;
#(
  parameter int               NUM_BINS  = DEF_NUM_BINS,
  parameter int               BAR_W     = DEF_BAR_W,
  parameter int               GAP_W     = DEF_GAP_W,
  parameter int               SCREEN_H  = DEF_SCREEN_H,
  parameter logic [RGB_W-1:0] BAR_COLOR = DEF_BAR_COLOR,
  parameter logic [RGB_W-1:0] BG_COLOR  = DEF_BG_COLOR
) (
  input logic                  clk,
  input logic                  reset,
  spectrum_draw_ctrl_if.master bus
);

  localparam int OFF_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  // Parameter sets that cannot be represented on the fixed-width ports are rejected.
  generate
    if (NUM_BINS * BAR_W > (1 << X_W)) begin : g_err_x_range
      $error("spectrum_draw_ctrl: NUM_BINS*BAR_W does not fit the 9-bit pix_x");
    end
    if (NUM_BINS < 1 || NUM_BINS > (1 << ADDR_W)) begin : g_err_bins
      $error("spectrum_draw_ctrl: NUM_BINS does not fit the 4-bit bin_addr");
    end
    if (SCREEN_H < 1 || SCREEN_H > (1 << Y_W)) begin : g_err_height
      $error("spectrum_draw_ctrl: SCREEN_H does not fit the 8-bit pix_y");
    end
    if (BAR_W < 2 || GAP_W < 0 || GAP_W > BAR_W) begin : g_err_bar
      $error("spectrum_draw_ctrl: BAR_W/GAP_W combination is not drawable");
    end
  endgenerate

  draw_state_e      r_state;
  draw_state_e      w_next_state;

  logic [ADDR_W-1:0] r_bin;
  logic [X_W-1:0]    r_x_base;
  logic [MAG_W-1:0]  r_height;
  logic              r_done;
  logic              r_overrun;

  logic              w_busy;
  logic              w_pix_valid;
  logic              w_start_frame;
  logic              w_ignored;
  logic              w_latch_height;
  logic              w_fin;
  logic              w_accept;
  logic              w_last_pixel;
  logic              w_final_bin;
  logic              w_next_bin;

  logic [OFF_W-1:0]  w_offset;
  logic [Y_W-1:0]    w_y;
  logic [MAG_W-1:0]  w_row_up;
  logic              w_in_bar;
  logic [RGB_W-1:0]  w_pix_color;

  assign w_accept    = w_pix_valid && bus.pix_ready;
  assign w_final_bin = (r_bin == ADDR_W'(NUM_BINS - 1));
  assign w_next_bin  = w_accept && w_last_pixel && !w_final_bin;

  // State register; reset always returns the sequencer to IDLE, abandoning any frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one read/wait pair per bar, then the bar's pixels, then FIN.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.frame_start) begin
          w_next_state = RD_ADDR;
        end
      end
      RD_ADDR: w_next_state = RD_WAIT;
      RD_WAIT: w_next_state = DRAW;
      DRAW: begin
        if (w_accept && w_last_pixel) begin
          w_next_state = w_final_bin ? FIN : RD_ADDR;
        end
      end
      FIN:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State-decoded controls; any frame_start outside IDLE (FIN included) is ignored.
  always_comb begin
    w_busy         = (r_state != IDLE);
    w_pix_valid    = (r_state == DRAW);
    w_start_frame  = (r_state == IDLE) && bus.frame_start;
    w_ignored      = (r_state != IDLE) && bus.frame_start;
    w_latch_height = (r_state == RD_WAIT);
    w_fin          = (r_state == FIN);
  end

  // Bar index, bar x origin, clamped height and the single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin     <= '0;
      r_x_base  <= '0;
      r_height  <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done    <= w_fin;
      r_overrun <= w_ignored;
      if (w_start_frame) begin
        r_bin    <= '0;
        r_x_base <= '0;
      end else if (w_next_bin) begin
        r_bin    <= r_bin + 1'b1;
        r_x_base <= r_x_base + X_W'(BAR_W);
      end
      if (w_latch_height) begin
        r_height <= clampHeight(bus.bin_data, SCREEN_H);
      end
    end
  end

  // Counters only move on an accepted pixel, so coordinates hold while the sink stalls.
  pixel_scan_counter #(
    .BAR_W    (BAR_W),
    .SCREEN_H (SCREEN_H),
    .OFF_W    (OFF_W),
    .Y_W      (Y_W)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_latch_height),
    .i_advance (w_accept),
    .o_offset  (w_offset),
    .o_y       (w_y),
    .o_last    (w_last_pixel)
  );

  // Pixel colour: bars grow from the bottom row, gap columns are always background.
  always_comb begin
    w_row_up    = MAG_W'(SCREEN_H - 1) - MAG_W'(w_y);
    w_in_bar    = (int'(w_offset) < (BAR_W - GAP_W));
    w_pix_color = BG_COLOR;
    if (w_in_bar && (w_row_up < r_height)) begin
      w_pix_color = BAR_COLOR;
    end
  end

  assign bus.bin_addr  = r_bin;
  assign bus.pix_valid = w_pix_valid;
  assign bus.pix_x     = r_x_base + X_W'(w_offset);
  assign bus.pix_y     = w_y;
  assign bus.pix_color = w_pix_color;
  assign bus.busy      = w_busy;
  assign bus.done      = r_done;
  assign bus.overrun   = r_overrun;

endmodule
